// File: rtl/tpg2_pkg.sv
// tpg2_pkg: pattern mode encodings and colour-bar table for the tpg2 test pattern generator.
package tpg2_pkg;
  typedef enum logic [1:0] {
    MODE_SOLID = 2'd0,
    MODE_RAMP  = 2'd1,
    MODE_BARS  = 2'd2,
    MODE_CHECK = 2'd3
  } modeT;
  // {R,G,B} on/off per bar, bar 0 (white) in the low bits, bar 7 (black) in the high bits
  localparam logic [23:0] BAR_TAB = 24'b000_001_100_101_010_011_110_111;
  function automatic logic [2:0] barBits(input logic [2:0] idx);
    return BAR_TAB[idx*3 +: 3];
  endfunction
endpackage

// File: rtl/tpg2_timing.sv
// tpg2_timing: h/v counters, frame-boundary latching of en/mode, frame count and raw sync/active decode.
module tpg2_timing
  import tpg2_pkg::*;
#(
  parameter int H_BITS  = 12,
  parameter int V_BITS  = 12,
  parameter int SQ_LOG2 = 3,
  parameter int FC_BITS = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [H_BITS-1:0]  tHS_START,
  input  logic [H_BITS-1:0]  tHS_END,
  input  logic [H_BITS-1:0]  tHACT_START,
  input  logic [H_BITS-1:0]  tHACT_END,
  input  logic [H_BITS-1:0]  tH_END,
  input  logic [V_BITS-1:0]  tVS_START,
  input  logic [V_BITS-1:0]  tVS_END,
  input  logic [V_BITS-1:0]  tVACT_START,
  input  logic [V_BITS-1:0]  tVACT_END,
  input  logic [V_BITS-1:0]  tV_END,
  output logic [H_BITS-1:0]  x,
  output logic               yBit,
  output logic               hsRaw,
  output logic               vsRaw,
  output logic               act,
  output logic               sofRaw,
  output logic               eolRaw,
  output modeT               modeL,
  output logic [FC_BITS-1:0] frameCnt
);
  logic [H_BITS-1:0] h;
  logic [V_BITS-1:0] v, y;
  logic enL, lineEnd, frameEnd;
  assign lineEnd  = h == tH_END;
  assign frameEnd = enL && lineEnd && v == tV_END;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h        <= '0;
      v        <= '0;
      enL      <= 1'b0;
      modeL    <= MODE_SOLID;
      frameCnt <= '0;
    end else begin
      // while idle the latch stays open so en is picked up on any cycle
      if (!enL || frameEnd) begin
        enL   <= en;
        modeL <= modeT'(mode);
      end
      if (!enL) begin
        h <= '0;
        v <= '0;
      end else begin
        h <= lineEnd ? '0 : h + 1'b1;
        if (lineEnd) v <= (v == tV_END) ? '0 : v + 1'b1;
      end
      if (frameEnd) frameCnt <= frameCnt + 1'b1;
    end
  end
  always_comb begin
    x      = h - tHACT_START;
    y      = v - tVACT_START;
    yBit   = y[SQ_LOG2];
    hsRaw  = enL && h >= tHS_START && h < tHS_END;
    vsRaw  = enL && v >= tVS_START && v < tVS_END;
    act    = enL && h >= tHACT_START && h < tHACT_END && v >= tVACT_START && v < tVACT_END;
    sofRaw = act && x == '0 && y == '0;
    eolRaw = act && h == tHACT_END - 1'b1;
  end
endmodule

// File: rtl/tpg2.sv
// tpg2: video test pattern generator with solid, ramp, colour-bar and checker modes.
module tpg2
  import tpg2_pkg::*;
#(
  parameter int PW      = 8,
  parameter int H_BITS  = 12,
  parameter int V_BITS  = 12,
  parameter int SQ_LOG2 = 3,
  parameter int FC_BITS = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [3*PW-1:0]    solid_rgb,
  input  logic [H_BITS-1:0]  bar_w,
  input  logic               hs_pol,
  input  logic               vs_pol,
  input  logic [H_BITS-1:0]  tHS_START,
  input  logic [H_BITS-1:0]  tHS_END,
  input  logic [H_BITS-1:0]  tHACT_START,
  input  logic [H_BITS-1:0]  tHACT_END,
  input  logic [H_BITS-1:0]  tH_END,
  input  logic [V_BITS-1:0]  tVS_START,
  input  logic [V_BITS-1:0]  tVS_END,
  input  logic [V_BITS-1:0]  tVACT_START,
  input  logic [V_BITS-1:0]  tVACT_END,
  input  logic [V_BITS-1:0]  tV_END,
  output logic               hs,
  output logic               vs,
  output logic               vld,
  output logic [3*PW-1:0]    rgb,
  output logic               sof,
  output logic               eol,
  output logic [FC_BITS-1:0] frame_cnt
);
  logic [H_BITS-1:0] x, barCnt, cntN;
  logic yBit, hsRaw, vsRaw, act, sofRaw, eolRaw, wrap;
  logic [2:0] barIdx, idxE, bb;
  logic [3*PW-1:0] pix, barRgb;
  modeT modeL;
  tpg2_timing #(.H_BITS(H_BITS), .V_BITS(V_BITS), .SQ_LOG2(SQ_LOG2), .FC_BITS(FC_BITS)) uTiming (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .tHS_START(tHS_START), .tHS_END(tHS_END), .tHACT_START(tHACT_START), .tHACT_END(tHACT_END), .tH_END(tH_END),
    .tVS_START(tVS_START), .tVS_END(tVS_END), .tVACT_START(tVACT_START), .tVACT_END(tVACT_END), .tV_END(tV_END),
    .x(x), .yBit(yBit), .hsRaw(hsRaw), .vsRaw(vsRaw), .act(act), .sofRaw(sofRaw), .eolRaw(eolRaw),
    .modeL(modeL), .frameCnt(frame_cnt)
  );
  // the first active pixel of a line restarts the bar counter without needing a separate clear
  always_comb begin
    idxE   = (x == {H_BITS{1'b0}}) ? 3'd0 : barIdx;
    cntN   = ((x == {H_BITS{1'b0}}) ? {H_BITS{1'b0}} : barCnt) + 1'b1;
    wrap   = cntN >= bar_w;
    bb     = barBits(idxE);
    barRgb = {{PW{bb[2]}}, {PW{bb[1]}}, {PW{bb[0]}}};
    pix    = modeL == MODE_SOLID ? solid_rgb :
             modeL == MODE_RAMP  ? {3{x[PW-1:0]}} :
             modeL == MODE_BARS  ? barRgb :
             {3*PW{x[SQ_LOG2] ^ yBit ^ frame_cnt[0]}};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hs     <= ~hs_pol;
      vs     <= ~vs_pol;
      vld    <= 1'b0;
      sof    <= 1'b0;
      eol    <= 1'b0;
      rgb    <= '0;
      barIdx <= '0;
      barCnt <= '0;
    end else begin
      hs  <= hsRaw ^ ~hs_pol;
      vs  <= vsRaw ^ ~vs_pol;
      vld <= act;
      sof <= sofRaw;
      eol <= eolRaw;
      rgb <= act ? pix : '0;
      if (act) begin
        barIdx <= !wrap ? idxE : (idxE == 3'd7 ? idxE : idxE + 3'd1);
        barCnt <= wrap ? '0 : cntN;
      end
    end
  end
endmodule

// File: tb/tb_tpg2.sv
// tb_tpg2: directed and randomized checks of tpg2 against a frame-position reference model.
module tb_tpg2;
  localparam int PW = 8, HB = 12, VB = 12, SQ = 1, FB = 8;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, en, hs_pol, vs_pol, hs, vs, vld, sof, eol;
  logic [1:0] mode;
  logic [3*PW-1:0] solid_rgb, rgb;
  logic [HB-1:0] bar_w, tHS_START, tHS_END, tHACT_START, tHACT_END, tH_END;
  logic [VB-1:0] tVS_START, tVS_END, tVACT_START, tVACT_END, tV_END;
  logic [FB-1:0] frame_cnt;
  tpg2 #(.PW(PW), .H_BITS(HB), .V_BITS(VB), .SQ_LOG2(SQ), .FC_BITS(FB)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .solid_rgb(solid_rgb), .bar_w(bar_w),
    .hs_pol(hs_pol), .vs_pol(vs_pol),
    .tHS_START(tHS_START), .tHS_END(tHS_END), .tHACT_START(tHACT_START), .tHACT_END(tHACT_END), .tH_END(tH_END),
    .tVS_START(tVS_START), .tVS_END(tVS_END), .tVACT_START(tVACT_START), .tVACT_END(tVACT_END), .tV_END(tV_END),
    .hs(hs), .vs(vs), .vld(vld), .rgb(rgb), .sof(sof), .eol(eol), .frame_cnt(frame_cnt)
  );
  int checks = 0, errors = 0;
  int mT = 0, mEn = 0, mMode = 0, mFc = 0;
  int cHs, cVld, cSof, cEol;
  logic [23:0] sofRgb;
  logic [23:0] barTab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  // model: position in frame mT -> (h,v); expected outputs from the pre-edge position
  task automatic step();
    int h, v, x, y, idx, lineLen;
    bit a, rh, rv;
    logic [23:0] c;
    logic [36:0] expV, obs;
    lineLen = int'(tH_END) + 1;
    h = mT % lineLen;
    v = mT / lineLen;
    x = h - int'(tHACT_START);
    y = v - int'(tVACT_START);
    a  = rst_n && mEn != 0 && h >= int'(tHACT_START) && h < int'(tHACT_END) &&
         v >= int'(tVACT_START) && v < int'(tVACT_END);
    rh = rst_n && mEn != 0 && h >= int'(tHS_START) && h < int'(tHS_END);
    rv = rst_n && mEn != 0 && v >= int'(tVS_START) && v < int'(tVS_END);
    c = 24'h0;
    if (a) begin
      idx = x / int'(bar_w);
      if (idx > 7) idx = 7;
      case (mMode)
        0: c = solid_rgb;
        1: c = {3{8'(x)}};
        2: c = barTab[idx];
        default: c = ((((x >> SQ) ^ (y >> SQ) ^ mFc) & 1) != 0) ? 24'hFFFFFF : 24'h0;
      endcase
    end
    if (!rst_n) begin
      mT = 0; mEn = 0; mMode = 0; mFc = 0;
    end else if (mEn == 0) begin
      mEn = int'(en); mMode = int'(mode); mT = 0;
    end else if (mT == lineLen * (int'(tV_END) + 1) - 1) begin
      mT = 0; mFc = (mFc + 1) % 256; mEn = int'(en); mMode = int'(mode);
    end else mT++;
    expV = {rh ? hs_pol : ~hs_pol, rv ? vs_pol : ~vs_pol, a, a && x == 0 && y == 0,
            a && h == int'(tHACT_END) - 1, c, 8'(mFc)};
    @(posedge clk);
    #1;
    obs = {hs, vs, vld, sof, eol, rgb, frame_cnt};
    checks++;
    assert (obs === expV) else begin
      errors++;
      $error("FAIL pixel h=%0d v=%0d obs={hs,vs,vld,sof,eol,rgb,fc}=%h exp=%h", h, v, obs, expV);
    end
    cHs  += int'(hs === hs_pol);
    cVld += int'(vld === 1'b1);
    cSof += int'(sof === 1'b1);
    cEol += int'(eol === 1'b1);
    if (sof === 1'b1) sofRgb = rgb;
  endtask

  task automatic check(input string tag, input int obs, input int expV);
    checks++;
    assert (obs === expV) else begin
      errors++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, expV);
    end
  endtask

  // one full frame at the fixed timing; mode changes mid-frame and again just before the frame end
  task automatic runFrame(input int midMode, input int nextMode, input int expHs, input bit rnd);
    int n;
    n = (int'(tH_END) + 1) * (int'(tV_END) + 1);
    cHs = 0; cVld = 0; cSof = 0; cEol = 0;
    for (int i = 0; i < n; i++) begin
      if (rnd) solid_rgb = $urandom;
      if (i == n / 2) mode = 2'(midMode);
      if (i == n - 1) mode = 2'(nextMode);
      step();
    end
    check("hs_active_clks", cHs, expHs);
    check("vld_clks", cVld, 100);
    check("sof_count", cSof, 1);
    check("eol_count", cEol, 10);
  endtask

  initial begin
    rst_n = 0; en = 0; mode = 0; solid_rgb = 24'h112233; bar_w = 1; hs_pol = 1; vs_pol = 1;
    tHS_START = 10; tHS_END = 20; tHACT_START = 40; tHACT_END = 50; tH_END = 60;
    tVS_START = 11; tVS_END = 21; tVACT_START = 25; tVACT_END = 35; tV_END = 40;
    repeat (3) step();
    check("reset_outputs", int'({hs, vs, vld, sof, eol}), 0);
    check("reset_rgb", int'(rgb), 0);
    rst_n = 1; en = 1;
    step();
    runFrame(1, 1, 410, 0);
    check("frame_cnt_after_frame", int'(frame_cnt), 1);
    runFrame(2, 2, 410, 0);
    runFrame(2, 2, 410, 0);
    bar_w = HB'($urandom_range(2, 4));
    runFrame(3, 3, 410, 1);
    runFrame(3, 3, 410, 1);
    check("check_frame4_origin", int'(sofRgb), 0);
    runFrame(0, 0, 410, 1);
    check("check_frame5_origin", int'(sofRgb), 24'hFFFFFF);
    hs_pol = 0;
    runFrame(1, 1, 410, 1);
    tHS_START = 30;
    runFrame(0, 2, 0, 1);
    tHS_START = 10;
    repeat (700) step();
    rst_n = 0;
    repeat (3) step();
    check("midreset_frame_cnt", int'(frame_cnt), 0);
    check("midreset_hs_inactive", int'(hs), 1);
    check("midreset_vld_rgb", int'({vld, rgb}), 0);
    tH_END = HB'($urandom_range(14, 40));
    tHS_START = HB'($urandom_range(0, int'(tH_END)));
    tHS_END = HB'($urandom_range(0, int'(tH_END)));
    tHACT_START = HB'($urandom_range(0, 10));
    tHACT_END = HB'($urandom_range(0, int'(tH_END)));
    tV_END = VB'($urandom_range(6, 20));
    tVS_START = VB'($urandom_range(0, int'(tV_END)));
    tVS_END = VB'($urandom_range(0, int'(tV_END)));
    tVACT_START = VB'($urandom_range(0, 4));
    tVACT_END = VB'($urandom_range(0, int'(tV_END)));
    bar_w = HB'($urandom_range(1, 4));
    rst_n = 1;
    for (int i = 0; i < 6000; i++) begin
      en = $urandom_range(0, 19) != 0;
      mode = 2'($urandom);
      solid_rgb = $urandom;
      if ($urandom_range(0, 499) == 0) vs_pol = ~vs_pol;
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
